valu_acc_pack: RTL
==================

// Module: valu_acc_pack
// PURPOSE
// Downstream stage of the vector MAC ALU. Consumes its 32-bit signed dot-product results, accumulates
// them over a variable-length group, requantizes each group total to int8 (arith. shift + saturate),
// and packs four int8 lanes into one 32-bit word for writeback. Valid/ready on both sides.
// PARAMETERS
// ACC_W    32  accumulator width in bits (signed, >= 32)
// SHIFT_W  5   width of requantization shift amount
// PORTS
// clk_i        in   1        clock
// rst_ni       in   1        asynchronous reset, active low
// clear_i      in   1        synchronous flush: drop partial accumulation and lanes
// in_valid_i   in   1        dot_i beat valid
// in_ready_o   out  1        beat accepted when in_valid_i & in_ready_o
// dot_i        in   32       signed dot product from the vector ALU
// last_i       in   1        beat closes current accumulation group
// shift_i      in   SHIFT_W  right-shift amount, sampled on the accepted last beat
// out_valid_o  out  1        packed word valid
// out_ready_i  in   1        consumer ready
// packed_o     out  32       lane0=[7:0] .. lane3=[31:24], int8 two's complement
// sat_o        out  1        at least one lane of packed_o was clipped
// BEHAVIOUR
// - Reset: acc_q=0, lane_q=0, first_q=1, out_valid_o=0, packed_o=0, sat_o=0; in_ready_o=1 out of reset.
// - in_ready_o = !out_valid_o | out_ready_i (combinational); stalls every beat while output held.
// - Accepted beat: sum = (first_q ? 0 : acc_q) + sext(dot_i); wraps mod 2^ACC_W, no overflow flag.
//   Non-last beat: acc_q<=sum, first_q<=0. Last beat: requantize sum, first_q<=1.
// - Requantize: r = sum >>> shift_i (arithmetic); clip to [-128,127]; clip sets lane sat bit.
//   Shift and rounding computed in ACC_W+1 bits; no intermediate overflow.
// - Lane fill: last beat writes r into lane lane_q of staging register, lane_q++ (mod 4).
//   On lane_q==3 the staging word plus OR of lane sat bits loads packed_o/sat_o, out_valid_o<=1
//   next cycle (latency 1 cycle from 4th last beat). Staging lanes and sat bits clear after load.
// - Output: packed_o/sat_o stable while out_valid_o & !out_ready_i. Handshake clears out_valid_o
//   unless a new word loads same cycle (then stays 1 with new data; back-to-back, no bubble).
// - clear_i (priority over input beat, same cycle): acc_q=0, lane_q=0, first_q=1, staging cleared;
//   an already-valid packed_o is NOT dropped and completes its handshake normally.
// - Reset mid-operation: all state to reset values immediately, pending word lost.
// - shift_i >= ACC_W: result is 0 or -1 by sign (no rounding term).
// CONFIGURATION
// VALU_ACC_ROUND_EN defined: round-half-up, r = (sum + (1 << (shift_i-1))) >>> shift_i when shift_i > 0;
//   shift_i == 0 unchanged. Not defined: truncating arithmetic shift only. Ports identical both ways.
// TESTING
// 1 Four 1-beat groups dot=0x10,0x20,0xFFFFFFF0,0x7F, shift=0 -> packed_o=0x7FF02010, sat_o=0,
//   out_valid_o one cycle after 4th beat.
// 2 Saturation: groups 1000,-1000,0,5 shift=0 -> packed_o=0x0500807F, sat_o=1.
// 3 Group 100,200,301 (last on 3rd), shift=4 -> lane=0x25 without VALU_ACC_ROUND_EN, 0x26 with;
//   negative case -601 shift=4 -> 0xDA trunc, 0xDA round.
// 4 Backpressure: out_ready_i=0 after word complete -> in_ready_o=0, packed_o stable 10 cycles;
//   raise out_ready_i -> handshake, in_ready_o=1 same cycle, next word back-to-back without bubble.
// 5 clear_i after 2 lanes and mid-group beat -> next 4 groups produce fresh word, lane0 at [7:0],
//   no residue of earlier sums.
// 6 rst_ni low mid-group with out_valid_o=1 -> all outputs 0 asynchronously, in_ready_o=1 after.

Source files
------------

// File: rtl/valu_acc_pack.sv
// Accumulates signed dot-product groups, requantizes each total to int8 and packs four lanes per word.
// Build option: define VALU_ACC_ROUND_EN for round-half-up before the shift (default: truncate).
module valu_acc_pack #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        dot_i,
  input  logic               last_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        packed_o,
  output logic               sat_o
);

  localparam int unsigned MaxShift = (1 << SHIFT_W) - 1;
  localparam logic signed [ACC_W:0] QMax = 127;
  localparam logic signed [ACC_W:0] QMin = -128;

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_first;
  logic [1:0]              r_lane;
  logic [31:0]             r_stage;
  logic [3:0]              r_stage_sat;
  logic                    r_out_valid;
  logic [31:0]             r_packed;
  logic                    r_sat;

  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_load;
  logic                    w_big_shift;
  logic signed [ACC_W-1:0] w_dot_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W:0]   w_wide;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic [7:0]              w_lane_val;
  logic                    w_lane_sat;
  logic [31:0]             w_stage_next;
  logic [3:0]              w_sat_next;

  assign in_ready_o  = !r_out_valid | out_ready_i;
  assign out_valid_o = r_out_valid;
  assign packed_o    = r_packed;
  assign sat_o       = r_sat;

  // clear_i wins over a simultaneous beat, so the beat is dropped.
  assign w_accept    = in_valid_i & in_ready_o & !clear_i;
  assign w_last_beat = w_accept & last_i;
  assign w_load      = w_last_beat & (r_lane == 2'd3);

  assign w_dot_ext = ACC_W'(signed'(dot_i));
  assign w_sum     = (r_first ? '0 : r_acc) + w_dot_ext;

  // Shifts at or beyond the accumulator width only exist for wide SHIFT_W.
  if (MaxShift >= ACC_W) begin : g_big_shift
    assign w_big_shift = (32'(shift_i) >= ACC_W);
  end else begin : g_no_big_shift
    assign w_big_shift = 1'b0;
  end

  always_comb begin
    w_wide = {w_sum[ACC_W-1], w_sum};
    w_rnd  = w_wide;
`ifdef VALU_ACC_ROUND_EN
    if (shift_i != '0 && !w_big_shift) begin
      w_rnd = w_wide + ((ACC_W+1)'(1) << (shift_i - SHIFT_W'(1)));
    end
`endif
    if (w_big_shift) begin
      w_shr = {(ACC_W+1){w_sum[ACC_W-1]}};
    end else begin
      w_shr = w_rnd >>> shift_i;
    end

    w_lane_sat = 1'b0;
    w_lane_val = w_shr[7:0];
    if (w_shr > QMax) begin
      w_lane_val = 8'h7f;
      w_lane_sat = 1'b1;
    end else if (w_shr < QMin) begin
      w_lane_val = 8'h80;
      w_lane_sat = 1'b1;
    end
  end

  always_comb begin
    w_stage_next = r_stage;
    w_sat_next   = r_stage_sat;
    unique case (r_lane)
      2'd0: w_stage_next[7:0]   = w_lane_val;
      2'd1: w_stage_next[15:8]  = w_lane_val;
      2'd2: w_stage_next[23:16] = w_lane_val;
      2'd3: w_stage_next[31:24] = w_lane_val;
      default: ;
    endcase
    w_sat_next[r_lane] = w_lane_sat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_lane      <= 2'd0;
      r_stage     <= '0;
      r_stage_sat <= '0;
      r_out_valid <= 1'b0;
      r_packed    <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (clear_i) begin
        r_acc       <= '0;
        r_first     <= 1'b1;
        r_lane      <= 2'd0;
        r_stage     <= '0;
        r_stage_sat <= '0;
      end else if (w_accept) begin
        if (!last_i) begin
          r_acc   <= w_sum;
          r_first <= 1'b0;
        end else begin
          r_acc   <= '0;
          r_first <= 1'b1;
          r_lane  <= r_lane + 2'd1;
          if (w_load) begin
            r_stage     <= '0;
            r_stage_sat <= '0;
          end else begin
            r_stage     <= w_stage_next;
            r_stage_sat <= w_sat_next;
          end
        end
      end

      // A load can only happen when the previous word is absent or handshaking now.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_packed    <= w_stage_next;
        r_sat       <= |w_sat_next;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
